// File: rtl/ext_pipe_if.sv
// ext_pipe_if: handshake bundle for the immediate-extension unit.
//   flush               : synchronous clear of everything held in the unit
//   in_valid/in_ready   : request side handshake
//   in_imm/in_mode      : immediate and extension mode (0=ZERO 1=SIGN 2=LUI 3=SHL2)
//   out_valid/out_ready : result side handshake
//   out_data/out_err    : extended result and illegal-mode flag
// master = the side driving requests and consuming results; slave = ext_pipe.
interface ext_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [2:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_err;

  modport master (
    output flush, in_valid, in_imm, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  flush, in_valid, in_imm, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/ext_pipe.sv
// ext_pipe: registered IN_W -> OUT_W immediate extender with valid/ready
// handshake and a one-entry skid buffer.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : ext_pipe_if.slave (flush, in_* request side, out_* result side)
// Modes: 0=ZERO, 1=SIGN, 2=LUI, 3=SHL2 (sign extend then << 2), 4..7 illegal
// (data=0, err=1). Results come from the main register; the skid register
// catches one extra input while the main register is stalled, so in_ready
// depends only on registered state.
module ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  ext_pipe_if.slave    bus
);

  generate
    if (IN_W < 2) begin : g_bad_in_w
      $error("ext_pipe: IN_W must be >= 2");
    end
    if (OUT_W < IN_W + 2) begin : g_bad_out_w
      $error("ext_pipe: OUT_W must be >= IN_W+2");
    end
  endgenerate

  localparam int EXT_W = OUT_W - IN_W;

  // ---------------------------------------------------------------------------
  // Extension arithmetic on the input side
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] zero_ext;
  logic [OUT_W-1:0] sign_ext;
  logic [OUT_W-1:0] lui_ext;
  logic [OUT_W-1:0] shl2_ext;
  logic [OUT_W-1:0] ext_data;
  logic             ext_err;

  assign zero_ext = {{EXT_W{1'b0}}, bus.in_imm};
  assign sign_ext = {{EXT_W{bus.in_imm[IN_W-1]}}, bus.in_imm};
  assign lui_ext  = {bus.in_imm, {EXT_W{1'b0}}};
  // Top two bits shifted out are sign copies, so dropping them is lossless.
  assign shl2_ext = sign_ext << 2;

  always_comb begin
    ext_data = '0;
    ext_err  = 1'b0;
    case (bus.in_mode)
      3'd0:    ext_data = zero_ext;
      3'd1:    ext_data = sign_ext;
      3'd2:    ext_data = lui_ext;
      3'd3:    ext_data = shl2_ext;
      default: ext_err  = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Main and skid registers
  // ---------------------------------------------------------------------------
  logic             main_valid_q, main_valid_d;
  logic [OUT_W-1:0] main_data_q,  main_data_d;
  logic             main_err_q,   main_err_d;
  logic             skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0] skid_data_q,  skid_data_d;
  logic             skid_err_q,   skid_err_d;

  logic accept;
  logic drain;

  assign accept = bus.in_valid && !skid_valid_q;
  assign drain  = main_valid_q && bus.out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_err_d   = main_err_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_err_d   = skid_err_q;

    if (bus.flush) begin
      // Data registers keep their stale contents; only the valids matter.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain) begin
      // Main slot is free this edge. The skid entry is older than anything
      // on the input, and accept is already 0 whenever the skid is full.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_err_d   = skid_err_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = ext_data;
        main_err_d   = ext_err;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      // Main stalled: park the new input in the skid register.
      skid_valid_d = 1'b1;
      skid_data_d  = ext_data;
      skid_err_d   = ext_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_err_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_err_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_err_q   <= main_err_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_err_q   <= skid_err_d;
    end
  end

  assign bus.in_ready  = !skid_valid_q;
  assign bus.out_valid = main_valid_q;
  assign bus.out_data  = main_data_q;
  assign bus.out_err   = main_err_q;

endmodule
